// File: rtl/xor_stream_decryptor.sv
// Serial XOR stream decryptor: loads a key and a ciphertext bit-serially on one wire,
// XORs the ciphertext with the repeated key and shifts the plaintext out MSB first.
module xor_stream_decryptor #(
    parameter int MSG_SIZE = 128,
    parameter int KEY_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        iData_in,
    input  logic                        iKey_flag,
    input  logic                        iCipher_flag,
    output logic                        oData_out,
    output logic                        oData_flag,
    output logic                        oDecrypt_status,
    output logic [$clog2(MSG_SIZE):0]   oBit_counter
);

    localparam int CNT_W  = $clog2(MSG_SIZE) + 1;
    localparam int KCNT_W = $clog2(KEY_SIZE) + 1;
    localparam int IDX_W  = $clog2(MSG_SIZE);

    localparam logic [CNT_W-1:0]  CT_LAST  = CNT_W'(MSG_SIZE - 1);
    localparam logic [CNT_W-1:0]  CT_FULL  = CNT_W'(MSG_SIZE);
    localparam logic [KCNT_W-1:0] KEY_LAST = KCNT_W'(KEY_SIZE - 1);
    localparam logic [KCNT_W-1:0] KEY_FULL = KCNT_W'(KEY_SIZE);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(MSG_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        WAIT_CT,
        LOAD_CT,
        DECRYPT,
        SEND
    } state_t;

    state_t                state;
    logic [KEY_SIZE-1:0]   key_reg;
    logic [MSG_SIZE-1:0]   ct_reg;
    logic [MSG_SIZE-1:0]   pt_reg;
    logic [KCNT_W-1:0]     key_cnt;
    logic [CNT_W-1:0]      idx;
    logic [IDX_W-1:0]      bit_sel;

    // Bit i of the pad is key bit (i mod KEY_SIZE), i.e. the key replicated across the message.
    function automatic logic [MSG_SIZE-1:0] build_pad(input logic [KEY_SIZE-1:0] k);
        logic [MSG_SIZE-1:0] p;
        for (int i = 0; i < MSG_SIZE; i++) begin
            p[i] = k[i % KEY_SIZE];
        end
        return p;
    endfunction

    assign bit_sel = IDX_MAX - idx[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            key_reg         <= '0;
            ct_reg          <= '0;
            pt_reg          <= '0;
            key_cnt         <= '0;
            idx             <= '0;
            oBit_counter    <= '0;
            oData_out       <= 1'b0;
            oData_flag      <= 1'b0;
            oDecrypt_status <= 1'b0;
        end else if (ena) begin
            oDecrypt_status <= 1'b0;
            case (state)
                IDLE: begin
                    if (iKey_flag) begin
                        key_reg <= {key_reg[KEY_SIZE-2:0], iData_in};
                        key_cnt <= KCNT_W'(1);
                        state   <= LOAD_KEY;
                    end
                end
                LOAD_KEY: begin
                    if (iKey_flag && key_cnt < KEY_FULL) begin
                        key_reg <= {key_reg[KEY_SIZE-2:0], iData_in};
                        key_cnt <= key_cnt + 1'b1;
                        if (key_cnt == KEY_LAST) state <= WAIT_CT;
                    end
                end
                WAIT_CT: begin
                    // A new key takes priority over starting a ciphertext load.
                    if (iKey_flag) begin
                        key_reg <= {key_reg[KEY_SIZE-2:0], iData_in};
                        key_cnt <= KCNT_W'(1);
                        state   <= LOAD_KEY;
                    end else if (iCipher_flag) begin
                        ct_reg       <= {ct_reg[MSG_SIZE-2:0], iData_in};
                        oBit_counter <= CNT_W'(1);
                        state        <= LOAD_CT;
                    end
                end
                LOAD_CT: begin
                    if (iCipher_flag && oBit_counter < CT_FULL) begin
                        ct_reg       <= {ct_reg[MSG_SIZE-2:0], iData_in};
                        oBit_counter <= oBit_counter + 1'b1;
                        if (oBit_counter == CT_LAST) state <= DECRYPT;
                    end
                end
                DECRYPT: begin
                    pt_reg          <= ct_reg ^ build_pad(key_reg);
                    oDecrypt_status <= 1'b1;
                    idx             <= '0;
                    state           <= SEND;
                end
                SEND: begin
                    // idx reaching MSG_SIZE marks the cycle after the last bit went out.
                    if (idx == CT_FULL) begin
                        oData_flag   <= 1'b0;
                        oData_out    <= 1'b0;
                        oBit_counter <= '0;
                        state        <= WAIT_CT;
                    end else begin
                        oData_flag <= 1'b1;
                        oData_out  <= pt_reg[bit_sel];
                        idx        <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_stream_decryptor.sv
// Scoreboard bench for xor_stream_decryptor: expected plaintext bits are queued when the
// ciphertext is driven and checked bit by bit as the serial output appears.
module tb_xor_stream_decryptor;

    localparam int MSG = 128;
    localparam int KEY = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         data_in;
    logic         key_flag;
    logic         ct_flag;
    logic         data_out;
    logic         data_flag;
    logic         dec_status;
    logic [7:0]   bit_counter;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q[$];
    int   flag_cycles = 0;
    int   pulses = 0;
    int   bit_no = 0;
    logic ena_prev = 1'b1;
    logic e;

    localparam logic [127:0] PT_RT = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] CT_RT = PT_RT ^ {16{8'h3C}};

    always #5 clk = ~clk;

    xor_stream_decryptor #(.MSG_SIZE(MSG), .KEY_SIZE(KEY)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .iData_in        (data_in),
        .iKey_flag       (key_flag),
        .iCipher_flag    (ct_flag),
        .oData_out       (data_out),
        .oData_flag      (data_flag),
        .oDecrypt_status (dec_status),
        .oBit_counter    (bit_counter)
    );

    always @(posedge clk) ena_prev <= ena;

    // Scoreboard: every output cycle that the DUT actually advanced pops one expected bit.
    always @(negedge clk) begin
        if (dec_status && ena_prev) pulses++;
        if (data_flag && ena_prev) begin
            flag_cycles++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream_extra bit %0d: got %b with data_flag high, required no output", bit_no, data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_err++;
                    $display("FAIL stream_bit[%0d]: got %b, required %b", bit_no, data_out, e);
                end
            end
            bit_no++;
        end
    end

    task automatic clear_stats();
        flag_cycles = 0;
        pulses      = 0;
        bit_no      = 0;
    endtask

    task automatic send_key(input logic [7:0] k, input bit gap);
        for (int i = 0; i < KEY; i++) begin
            if (gap && i != 0 && i % 5 == 0) begin
                repeat (3) begin
                    @(negedge clk);
                    key_flag = 1'b0;
                    data_in  = 1'($urandom);
                end
            end
            @(negedge clk);
            key_flag = 1'b1;
            data_in  = k[KEY-1-i];
        end
        @(negedge clk);
        key_flag = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic send_ct(input logic [127:0] ct, input logic [127:0] expv, input bit gap, input int nbits);
        if (nbits == MSG) begin
            for (int i = MSG - 1; i >= 0; i--) exp_q.push_back(expv[i]);
        end
        for (int i = 0; i < nbits; i++) begin
            if (gap && i != 0 && i % 5 == 0) begin
                repeat (3) begin
                    @(negedge clk);
                    ct_flag = 1'b0;
                    data_in = 1'($urandom);
                end
            end
            @(negedge clk);
            ct_flag = 1'b1;
            data_in = ct[MSG-1-i];
        end
        @(negedge clk);
        ct_flag = 1'b0;
        data_in = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        int c = 0;
        to = 1'b0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !data_flag)) begin
            @(negedge clk);
            c++;
            if (c > 600) begin
                to = 1'b1;
                exp_q.delete();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; key_flag = 1'b0; ct_flag = 1'b0; data_in = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({data_out, data_flag, dec_status} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required 000", {data_out, data_flag, dec_status});
        end
        n_vec++;
        if (bit_counter !== 8'd0) begin
            n_err++;
            $display("FAIL reset_counter: got %0d, required 0", bit_counter);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ct_flag = 1'b1;
            data_in = 1'b1;
        end
        @(negedge clk);
        ct_flag = 1'b0;
        data_in = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bit_counter !== 8'd0 || data_flag !== 1'b0) begin
            n_err++;
            $display("FAIL no_key_ct_ignored: got counter %0d flag %b, required 0 0", bit_counter, data_flag);
        end
    endtask

    task automatic test_zero_ct();
        bit to;
        clear_stats();
        send_key(8'hA5, 1'b0);
        send_ct(128'h0, {16{8'hA5}}, 1'b0, MSG);
        n_vec++;
        if (bit_counter !== 8'd128) begin
            n_err++;
            $display("FAIL ct_count_full: got %0d, required 128", bit_counter);
        end
        @(negedge clk);
        n_vec++;
        if ({dec_status, data_flag} !== 2'b10) begin
            n_err++;
            $display("FAIL decrypt_pulse: got status/flag %b, required 10", {dec_status, data_flag});
        end
        @(negedge clk);
        n_vec++;
        if ({dec_status, data_flag} !== 2'b01) begin
            n_err++;
            $display("FAIL first_bit_latency: got status/flag %b, required 01", {dec_status, data_flag});
        end
        wait_done(to);
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL zero_ct_timeout: got timeout, required stream end");
        end
        n_vec++;
        if (flag_cycles !== 128 || pulses !== 1) begin
            n_err++;
            $display("FAIL zero_ct_counts: got %0d flagged / %0d pulses, required 128 / 1", flag_cycles, pulses);
        end
        n_vec++;
        if (bit_counter !== 8'd0 || data_out !== 1'b0) begin
            n_err++;
            $display("FAIL zero_ct_after: got counter %0d out %b, required 0 0", bit_counter, data_out);
        end
    endtask

    task automatic run_message(input string name, input logic [7:0] k, input bit load_key,
                               input logic [127:0] pt, input bit gap);
        bit to;
        clear_stats();
        if (load_key) send_key(k, gap);
        send_ct(pt ^ {16{k}}, pt, gap, MSG);
        wait_done(to);
        n_vec++;
        if (to || flag_cycles !== 128 || pulses !== 1) begin
            n_err++;
            $display("FAIL %s_counts: got timeout=%0d %0d flagged / %0d pulses, required 0 128 / 1", name, to, flag_cycles, pulses);
        end
    endtask

    task automatic test_round_trip();
        bit to;
        clear_stats();
        send_key(8'h3C, 1'b0);
        send_ct(CT_RT, PT_RT, 1'b0, MSG);
        wait_done(to);
        n_vec++;
        if (to || flag_cycles !== 128 || pulses !== 1) begin
            n_err++;
            $display("FAIL round_trip_counts: got timeout=%0d %0d flagged / %0d pulses, required 0 128 / 1", to, flag_cycles, pulses);
        end
    endtask

    task automatic test_gapped();
        bit to;
        clear_stats();
        send_key(8'h3C, 1'b1);
        send_ct(CT_RT, PT_RT, 1'b1, MSG);
        wait_done(to);
        n_vec++;
        if (to || flag_cycles !== 128 || pulses !== 1) begin
            n_err++;
            $display("FAIL gapped_counts: got timeout=%0d %0d flagged / %0d pulses, required 0 128 / 1", to, flag_cycles, pulses);
        end
    endtask

    task automatic test_ena_freeze();
        logic [127:0] pt;
        logic         held;
        bit           to;
        int           c;
        pt = 128'hDEADBEEF_CAFEBABE_00112233_44556677;
        clear_stats();
        send_key(8'h5A, 1'b0);
        send_ct(pt ^ {16{8'h5A}}, pt, 1'b0, MSG);
        c = 0;
        while (bit_no != 41 && c < 400) begin
            @(negedge clk);
            #1;
            c++;
        end
        n_vec++;
        if (bit_no != 41) begin
            n_err++;
            $display("FAIL freeze_reach_bit40: got bit %0d, required 41", bit_no);
        end
        held = data_out;
        ena  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (data_out !== held || data_flag !== 1'b1 || bit_no != 41) begin
                n_err++;
                $display("FAIL freeze_hold[%0d]: got out %b flag %b bit %0d, required %b 1 41", i, data_out, data_flag, bit_no, held);
            end
        end
        ena = 1'b1;
        wait_done(to);
        n_vec++;
        if (to || flag_cycles !== 128 || pulses !== 1) begin
            n_err++;
            $display("FAIL freeze_counts: got timeout=%0d %0d flagged / %0d pulses, required 0 128 / 1", to, flag_cycles, pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt3;
        logic [127:0] pt4;
        bit           to;
        pt3 = {$urandom, $urandom, $urandom, $urandom};
        pt4 = {$urandom, $urandom, $urandom, $urandom};
        clear_stats();
        send_ct(pt3 ^ {16{8'h5A}}, pt3, 1'b0, MSG);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key_flag = 1'b1;
            ct_flag  = 1'b1;
            data_in  = 1'($urandom);
        end
        @(negedge clk);
        key_flag = 1'b0;
        ct_flag  = 1'b0;
        data_in  = 1'b0;
        wait_done(to);
        n_vec++;
        if (to || flag_cycles !== 128 || pulses !== 1 || bit_counter !== 8'd0) begin
            n_err++;
            $display("FAIL key_reuse: got timeout=%0d %0d flagged / %0d pulses / counter %0d, required 0 128 / 1 / 0", to, flag_cycles, pulses, bit_counter);
        end
        run_message("new_key_ff", 8'hFF, 1'b1, pt4, 1'b0);
    endtask

    task automatic test_reset_mid_ct();
        send_key(8'hC3, 1'b0);
        send_ct(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h0, 1'b0, 60);
        n_vec++;
        if (bit_counter !== 8'd60) begin
            n_err++;
            $display("FAIL partial_ct_count: got %0d, required 60", bit_counter);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({data_out, data_flag, dec_status} !== 3'b000 || bit_counter !== 8'd0) begin
            n_err++;
            $display("FAIL mid_ct_reset: got outputs %b counter %0d, required 000 0", {data_out, data_flag, dec_status}, bit_counter);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_message("after_reset", 8'h96, 1'b1, 128'hA5A5_0F0F_F0F0_5A5A_1357_9BDF_2468_ACE0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_ct();
        test_round_trip();
        test_gapped();
        test_ena_freeze();
        test_back_to_back();
        test_reset_mid_ct();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
